systolic_feeder: RTL
====================

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter: DATA_SIZE, default 2, element width in bits of A and B matrices.
REQ-002 Parameter: DRAIN_CYCLES, default 4, zero-padding cycles after the last skewed step.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 load_valid  input  1  write request for one matrix element.
REQ-006 load_ready  output  1  write accepted when high (IDLE only).
REQ-007 load_sel  input  1  0 = matrix A, 1 = matrix B.
REQ-008 load_row, load_col  input  2 each  element index, legal range 0..2.
REQ-009 load_data  input  DATA_SIZE  element value.
REQ-010 load_err  output  1  one-cycle pulse: accepted write with row or col = 3.
REQ-011 start  input  1  begin a feed sequence.
REQ-012 busy  output  1  high from the cycle after start acceptance until done.
REQ-013 done  output  1  one-cycle pulse at sequence end.
REQ-014 feed_valid  output  1  high while a skewed step is on the a/b outputs.
REQ-015 a1, a2, a3  output  DATA_SIZE each  row streams into the array west edge.
REQ-016 b1, b2, b3  output  DATA_SIZE each  column streams into the array north edge.

Function
REQ-017 Storage SHALL be two 3x3 register arrays A[i][j], B[i][j]; all outputs SHALL be registered.
REQ-018 States SHALL be IDLE, FEED, DRAIN: IDLE->FEED on start; FEED->DRAIN after step 4; DRAIN->IDLE after DRAIN_CYCLES cycles.
REQ-019 A write SHALL occur on an edge with load_valid & load_ready and row, col <= 2; load_ready = (state == IDLE).
REQ-020 A write with row or col = 3 SHALL leave storage unchanged and pulse load_err the next cycle; writes while not IDLE SHALL be ignored without load_err.
REQ-021 start SHALL be accepted only in IDLE; start while busy SHALL be ignored.
REQ-022 When a write and start are accepted on the same edge, the written value SHALL be used by the sequence.
REQ-023 With start accepted at edge E0, outputs after edge E0+s (s = 0..4) SHALL show step s: a(i+1) = A[i][s-i] and b(j+1) = B[s-j][j] when the index is 0..2, else 0; feed_valid = 1.
REQ-024 After edges E0+5 .. E0+4+DRAIN_CYCLES, all a/b SHALL be 0, feed_valid 0, busy 1.
REQ-025 After edge E0+5+DRAIN_CYCLES, done SHALL be 1 for exactly one cycle, busy 0, state IDLE; total busy length = 5 + DRAIN_CYCLES cycles.
REQ-026 In IDLE, a/b outputs SHALL be 0; matrix contents SHALL persist across sequences until overwritten.
REQ-027 A start asserted in the same cycle as done SHALL be accepted (state is IDLE at that edge).

Reset
REQ-028 reset low SHALL immediately clear A, B, state = IDLE, all a/b = 0, feed_valid = busy = done = load_err = 0, and load_ready = 1.
REQ-029 reset asserted mid-FEED or mid-DRAIN SHALL abort the sequence without a done pulse; operation resumes on the first edge after reset deasserts.

Verification
REQ-030 Load A = [[1,3,2],[2,1,2],[1,2,3]], B = [[1,2,3],[2,1,2],[3,1,3]], then start -> steps 0..4 give a = (1,0,0), (3,2,0), (2,1,1), (0,2,2), (0,0,3) and b = (1,0,0), (2,2,0), (3,1,3), (0,1,2), (0,0,3).
REQ-031 Same run -> feed_valid high for 5 cycles, then 4 zero cycles, done pulses at E0+9, busy high for 9 cycles.
REQ-032 Write A[3][0] = 2 -> load_err pulses once, A unchanged, and a replay matches REQ-030.
REQ-033 Write and start on the same edge with A[0][0] = 2 -> step 0 a1 = 2; start and writes during busy -> ignored, and load_ready = 0.
REQ-034 reset low at step 2 -> outputs 0 immediately, no done; after reset, start -> all outputs 0 (storage cleared).
REQ-035 start held high continuously -> back-to-back sequences, with the new E0 at the edge where done is high.

Source files
------------

// File: rtl/systolic_feeder.sv
// systolic_feeder: holds two 3x3 matrices and streams them skewed
// into the west (a) and north (b) edges of a 3x3 systolic array.
module systolic_feeder #(
  parameter int DATA_SIZE    = 2,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic                 load_sel,
  input  logic [1:0]           load_row,
  input  logic [1:0]           load_col,
  input  logic [DATA_SIZE-1:0] load_data,
  output logic                 load_err,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 feed_valid,
  output logic [DATA_SIZE-1:0] a1,
  output logic [DATA_SIZE-1:0] a2,
  output logic [DATA_SIZE-1:0] a3,
  output logic [DATA_SIZE-1:0] b1,
  output logic [DATA_SIZE-1:0] b2,
  output logic [DATA_SIZE-1:0] b3
);

  localparam int CW =
    (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN
  } state_t;

  typedef logic [2:0][2:0][DATA_SIZE-1:0] mat_t;
  typedef logic [2:0][DATA_SIZE-1:0]      vec_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_step;
  logic [2:0]    w_step_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  mat_t          r_ma;
  mat_t          r_mb;
  mat_t          w_ma_nxt;
  mat_t          w_mb_nxt;
  vec_t          r_av;
  vec_t          r_bv;
  vec_t          w_av;
  vec_t          w_bv;
  logic          r_busy;
  logic          r_done;
  logic          r_fv;
  logic          r_err;
  logic          w_busy_nxt;
  logic          w_done_nxt;
  logic          w_emit;
  logic [2:0]    w_s;
  logic          w_idle;
  logic          w_acc;
  logic          w_oob;
  logic          w_wr;
  logic          w_err_nxt;

  assign w_idle    = (r_state == S_IDLE);
  assign w_acc     = load_valid & w_idle;
  assign w_oob     = (load_row == 2'd3) |
                     (load_col == 2'd3);
  assign w_wr      = w_acc & ~w_oob;
  assign w_err_nxt = w_acc & w_oob;

  // Step 0 reads the post-write matrices so a same-edge write is seen.
  always_comb begin
    w_ma_nxt = r_ma;
    w_mb_nxt = r_mb;
    if (w_wr && !load_sel)
      w_ma_nxt[load_row][load_col] = load_data;
    if (w_wr && load_sel)
      w_mb_nxt[load_row][load_col] = load_data;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_emit      = 1'b0;
    w_s         = r_step;
    unique case (r_state)
      S_IDLE: begin
        w_s        = 3'd0;
        w_busy_nxt = 1'b0;
        if (start) begin
          w_state_nxt = S_FEED;
          w_step_nxt  = 3'd1;
          w_busy_nxt  = 1'b1;
          w_emit      = 1'b1;
        end
      end
      S_FEED: begin
        w_emit = 1'b1;
        if (r_step == 3'd4) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = '0;
        end else begin
          w_step_nxt = r_step + 3'd1;
        end
      end
      S_DRAIN: begin
        if (r_cnt == CMAX) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Skew: lane i carries the element whose indices sum to the step.
  always_comb begin
    w_av = '0;
    w_bv = '0;
    if (w_emit) begin
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < 3; k++) begin
          if (i + k == int'(w_s)) begin
            w_av[i] = w_ma_nxt[i][k];
            w_bv[i] = w_mb_nxt[k][i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_step  <= '0;
      r_cnt   <= '0;
      r_ma    <= '0;
      r_mb    <= '0;
      r_av    <= '0;
      r_bv    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_fv    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ma    <= w_ma_nxt;
      r_mb    <= w_mb_nxt;
      r_av    <= w_av;
      r_bv    <= w_bv;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_fv    <= w_emit;
      r_err   <= w_err_nxt;
    end
  end

  assign load_ready = w_idle;
  assign load_err   = r_err;
  assign busy       = r_busy;
  assign done       = r_done;
  assign feed_valid = r_fv;
  assign a1         = r_av[0];
  assign a2         = r_av[1];
  assign a3         = r_av[2];
  assign b1         = r_bv[0];
  assign b2         = r_bv[1];
  assign b3         = r_bv[2];

endmodule
